// File: rtl/alu_ctrl_stage_if.sv
// ALU control interface between the ID stage (master) and the ALU control
// stage (slave).
// Handshake: there is no valid/ready pair here. valid_i tags the ID slot as a
// real instruction; stall_o is a back-pressure request, and the master must
// hold every ID-side signal stable for as long as stall_o is high.
// dbg_state exposes the multiply sequencer state (1 = waiting on a multiply).
interface alu_ctrl_stage_if;
  logic [1:0] ALUOp_i;
  logic [9:0] funct_i;
  logic       valid_i;
  logic       stall_i;
  logic       flush_i;
  logic [3:0] ALUCtrl_o;
  logic       valid_o;
  logic       stall_o;
  logic       dbg_state;

  modport master (
    output ALUOp_i, funct_i, valid_i, stall_i, flush_i,
    input  ALUCtrl_o, valid_o, stall_o, dbg_state
  );

  modport slave (
    input  ALUOp_i, funct_i, valid_i, stall_i, flush_i,
    output ALUCtrl_o, valid_o, stall_o, dbg_state
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decodes ALUOp plus {funct7,funct3} into a 4-bit ALU code
// and registers it across the ID/EX boundary.
// Optional feature macro: MUL_MULTICYCLE_EN. When defined, a valid mul holds
// EX for MUL_LAT cycles and raises stall_o meanwhile. When undefined, mul is a
// single-cycle op, stall_o is tied low and MUL_LAT has no effect.
module alu_ctrl_stage #(
  parameter int MUL_LAT = 3
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_ctrl_stage_if.slave bus
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_XOR  = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_MUL  = 4'b0100;
  localparam logic [3:0] C_ADDI = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SRAI = 4'b0111;
  localparam logic [3:0] C_OR   = 4'b1000;

  // Out-of-range latencies would wrap the 4-bit counter; reject at elaboration.
  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_lat
    $error("alu_ctrl_stage: MUL_LAT must be in 2..15");
  end

  logic [6:0] w_funct7;
  logic [2:0] w_funct3;
  logic [3:0] w_code;
  logic [3:0] r_ctrl;
  logic       r_valid;

  assign w_funct7 = bus.funct_i[9:3];
  assign w_funct3 = bus.funct_i[2:0];

  // Combinational decode; every unlisted combination falls back to add.
  always_comb begin
    w_code = C_ADD;
    case (bus.ALUOp_i)
      2'b00: w_code = C_ADD;
      2'b01: w_code = C_SUB;
      2'b10: begin
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: w_code = C_ADD;
          {7'b0100000, 3'b000}: w_code = C_SUB;
          {7'b0000001, 3'b000}: w_code = C_MUL;
          {7'b0000000, 3'b111}: w_code = C_AND;
          {7'b0000000, 3'b100}: w_code = C_XOR;
          {7'b0000000, 3'b001}: w_code = C_SLL;
          {7'b0000000, 3'b110}: w_code = C_OR;
          default:              w_code = C_ADD;
        endcase
      end
      2'b11: begin
        if (w_funct3 == 3'b000)
          w_code = C_ADDI;
        else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101)
          w_code = C_SRAI;
        else
          w_code = C_ADD;
      end
      default: w_code = C_ADD;
    endcase
  end

`ifdef MUL_MULTICYCLE_EN
  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;

  // ID/EX register plus multiply sequencer; while waiting, inputs are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ctrl  <= C_ADD;
      r_valid <= 1'b0;
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.stall_i) begin
            r_ctrl  <= r_ctrl;
          end else if (bus.flush_i) begin
            r_ctrl  <= C_ADD;
            r_valid <= 1'b0;
          end else begin
            r_ctrl  <= w_code;
            r_valid <= bus.valid_i;
            if (w_code == C_MUL && bus.valid_i) begin
              r_state <= MUL_WAIT;
              r_cnt   <= 4'(MUL_LAT - 1);
            end
          end
        end
        MUL_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1)
            r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.stall_o   = (r_state == MUL_WAIT);
  assign bus.dbg_state = r_state;
`else
  // ID/EX register; mul retires in one cycle like any other op.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ctrl  <= C_ADD;
      r_valid <= 1'b0;
    end else if (bus.stall_i) begin
      r_ctrl  <= r_ctrl;
    end else if (bus.flush_i) begin
      r_ctrl  <= C_ADD;
      r_valid <= 1'b0;
    end else begin
      r_ctrl  <= w_code;
      r_valid <= bus.valid_i;
    end
  end

  assign bus.stall_o   = 1'b0;
  assign bus.dbg_state = 1'b0;
`endif

  assign bus.ALUCtrl_o = r_ctrl;
  assign bus.valid_o   = r_valid;

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Producer side of the ALU control interface: decodes ALUOp plus `{funct7,funct3}` in ID into the 4-bit ALU control code and registers it into the ID/EX boundary so the EX-stage ALU sees a stable `ALUCtrl`. It also sequences multi-cycle multiplies, holding the `mul` code in EX and requesting an upstream pipeline stall until the multiply's latency has elapsed. It sits between the main control/ID stage and the ALU, alongside the hazard detection unit.

## Interface

Parameters:
- `MUL_LAT`, 3: EX occupancy of a `mul` in cycles; legal 2..15.

Ports:
- `clk_i`  input  1  clock. One clock domain.
- `rst_i`  input  1  reset; synchronous, active-low.
- `ALUOp_i`  input  2  from main control. 00 = load/store, 01 = branch, 10 = R-type, 11 = I-type ALU.
- `funct_i`  input  10  `{funct7[6:0], funct3[2:0]}` of the ID instruction.
- `valid_i`  input  1  ID instruction is real (not a bubble).
- `stall_i`  input  1  hold request from hazard unit or cache.
- `flush_i`  input  1  replace the ID/EX slot with a bubble.
- `ALUCtrl_o`  output  4  registered ALU control code to EX.
- `valid_o`  output  1  registered; EX slot holds a real instruction.
- `stall_o`  output  1  multiply-busy stall request to IF/ID/hazard logic.

## Operation

- Codes: `and` 0000, `xor` 0001, `add` 0010, `sll` 0011, `mul` 0100, `addi` 0101, `sub` 0110, `srai` 0111, `or` 1000.
- Decode (combinational, internal):
  - ALUOp 00 → `add`; ALUOp 01 → `sub`.
  - ALUOp 10, keyed on funct7/funct3:
    - 0000000/000 → `add`; 0100000/000 → `sub`; 0000001/000 → `mul`.
    - 0000000/111 → `and`; 0000000/100 → `xor`; 0000000/001 → `sll`; 0000000/110 → `or`.
  - ALUOp 11: funct3 000 → `addi`; 0100000/101 → `srai`.
  - Any other combination → `add`.
- State machine: RUN, MUL_WAIT. 4-bit down counter `cnt`.
- RUN, per edge, in priority order:
  - `stall_i` = 1: hold everything. `stall_i` beats `flush_i`.
  - Else if `flush_i` = 1: `ALUCtrl_o` ← 0010, `valid_o` ← 0.
  - Else: `ALUCtrl_o` ← decode, `valid_o` ← `valid_i`. If the decode is `mul` and `valid_i` = 1, go to MUL_WAIT with `cnt` ← `MUL_LAT`−1.
- MUL_WAIT, per edge:
  - `ALUCtrl_o` and `valid_o` are held.
  - `stall_i` and `flush_i` are ignored.
  - `cnt` decrements; on the edge where `cnt` = 1, go to RUN.
- `stall_o` = (state == MUL_WAIT), decoded from the state register with no input paths.
- A `mul` funct with `valid_i` = 0 loads code 0100 but does not enter MUL_WAIT.

## Timing

- Reset: an edge with `rst_i` = 0 forces `ALUCtrl_o` = 0010, `valid_o` = 0, state RUN, `cnt` = 0, hence `stall_o` = 0. Applies mid-MUL_WAIT too, abandoning the multiply.
- Decode latency: 1 edge from ID inputs to `ALUCtrl_o`.
- Multiply, loaded at edge E:
  - `stall_o` = 1 for the `MUL_LAT`−1 cycles after E.
  - Then one RUN cycle with the `mul` still in EX and `stall_o` = 0.
  - The next instruction loads at edge E+`MUL_LAT`.
  - Total EX occupancy is `MUL_LAT` cycles.
- Back-to-back `mul`s each get the full occupancy; no overlap.
- Upstream must hold ID inputs stable while `stall_o` = 1. This block does not sample them during MUL_WAIT.

## Configuration

- `MUL_MULTICYCLE_EN` defined: MUL_WAIT sequencing as above; `MUL_LAT` in effect.
- Not defined:
  - `mul` loads and retires in one cycle like any other op.
  - MUL_WAIT and `cnt` are not built; `stall_o` is tied 0.
  - `MUL_LAT` is ignored.
  - Decode is unchanged.

## Test plan

- Reset: drive `rst_i` = 0 for one edge during arbitrary input → `ALUCtrl_o` = 0010, `valid_o` = 0, `stall_o` = 0.
- Decode sweep with `valid_i` = 1 and no stall/flush, each checked one edge later:
  - ALUOp 10: 0000000/111 → 0000; 0100000/000 → 0110; 0000000/001 → 0011; 0000000/110 → 1000.
  - ALUOp 11: 0100000/101 → 0111; funct3 000 → 0101.
  - ALUOp 00 → 0010; ALUOp 01 → 0110; ALUOp 10 with 1111111/010 → 0010.
- Multiply, macro on, `MUL_LAT` = 3: issue 0000001/000 followed by `xor` →
  - `ALUCtrl_o` = 0100 for 3 cycles.
  - `stall_o` high for exactly cycles 1–2.
  - `ALUCtrl_o` = 0001 after the 3rd edge.
- Hold/flush, with `ALUCtrl_o` = 0001 in EX:
  - `stall_i` = 1 with new `and` input → holds 0001.
  - `flush_i` = 1 → 0010 with `valid_o` = 0.
  - `stall_i` and `flush_i` together → holds.
  - `flush_i` asserted during MUL_WAIT → ignored.
- Reset at cycle 1 of MUL_WAIT → after that edge `stall_o` = 0 and `ALUCtrl_o` = 0010; next `add` loads normally.
- Macro off: issue `mul` then `or` → 0100 for one cycle then 1000; `stall_o` never asserts.
